usb_endp_router: RTL and testbench

//  Parametrised endpoint router between the SIE and CHANNELS bulk/interrupt endpoint pairs.

---
 rtl/usb_endp_pkg.sv | 16 +
 rtl/usb_endp_router_halt.sv | 47 ++++
 rtl/usb_endp_router.sv | 189 ++++++++++++++++++
 tb/tb_usb_endp_router.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_endp_pkg.sv
// rtl/usb_endp_pkg.sv - shared state encoding and endpoint-number helper for usb_endp_router
package usb_endp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_IN_XFER,
    ST_OUT_XFER
  } xfer_state_e;

  localparam logic [3:0] ENDP_CTRL = 4'd0;

  function automatic logic [3:0] endp_of(input int k, input int base, input int step);
    return 4'(base + step * k);
  endfunction

endpackage

// File: rtl/usb_endp_router_halt.sv
// rtl/usb_endp_router_halt.sv - per-channel ENDPOINT_HALT state (module usb_endp_halt)
// Requests are held pending and only take effect while the router is idle.
module usb_endp_halt (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic usb_reset_i,
  input  logic apply_i,
  input  logic set_i,
  input  logic clr_i,
  output logic halted_o,
  output logic toggle_reset_o
);

  logic set_pend, clr_pend;
  logic set_eff, clr_eff;

  assign set_eff = set_pend | set_i;
  assign clr_eff = clr_pend | clr_i;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      set_pend       <= 1'b0;
      clr_pend       <= 1'b0;
      halted_o       <= 1'b0;
      toggle_reset_o <= 1'b0;
    end else if (usb_reset_i) begin
      set_pend       <= 1'b0;
      clr_pend       <= 1'b0;
      halted_o       <= 1'b0;
      toggle_reset_o <= 1'b0;
    end else if (apply_i) begin
      // Clear beats set; a clear always resets the data toggle, halted or not.
      set_pend       <= 1'b0;
      clr_pend       <= 1'b0;
      toggle_reset_o <= clr_eff;
      if (clr_eff)
        halted_o <= 1'b0;
      else if (set_eff)
        halted_o <= 1'b1;
    end else begin
      set_pend       <= set_eff;
      clr_pend       <= clr_eff;
      toggle_reset_o <= 1'b0;
    end
  end

endmodule

// File: rtl/usb_endp_router.sv
// rtl/usb_endp_router.sv - SIE to ctrl/bulk endpoint router with halt and configured gating
// Optional USB_ENDP_ROUTER_STATS_EN adds per-channel completed-transaction counters.
module usb_endp_router
  import usb_endp_pkg::*;
#(
  parameter int CHANNELS  = 1,
  parameter int BULK_BASE = 1,
  parameter int ENDP_STEP = 2
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  usb_reset_i,
  input  logic                  configured_i,
  input  logic [3:0]            endp_i,
  input  logic                  in_req_i,
  input  logic                  in_ready_i,
  input  logic                  in_data_ack_i,
  input  logic                  out_valid_i,
  input  logic                  out_ready_i,
  input  logic                  out_err_i,
  output logic [7:0]            in_data_o,
  output logic                  in_valid_o,
  output logic                  in_zlp_o,
  output logic                  in_nak_o,
  output logic                  out_nak_o,
  output logic                  stall_o,
  input  logic [7:0]            ctrl_in_data_i,
  input  logic                  ctrl_in_valid_i,
  input  logic                  ctrl_in_zlp_i,
  input  logic                  ctrl_stall_i,
  output logic                  ctrl_in_req_o,
  output logic                  ctrl_in_ready_o,
  output logic                  ctrl_out_ready_o,
  input  logic [8*CHANNELS-1:0] bulk_in_data_i,
  input  logic [CHANNELS-1:0]   bulk_in_valid_i,
  input  logic [CHANNELS-1:0]   bulk_out_nak_i,
  output logic [CHANNELS-1:0]   bulk_in_req_o,
  output logic [CHANNELS-1:0]   bulk_in_ready_o,
  output logic [CHANNELS-1:0]   bulk_out_ready_o,
  input  logic [CHANNELS-1:0]   halt_set_i,
  input  logic [CHANNELS-1:0]   halt_clr_i,
  output logic [CHANNELS-1:0]   halted_o,
  output logic [CHANNELS-1:0]   toggle_reset_o
`ifdef USB_ENDP_ROUTER_STATS_EN
  ,
  input  logic [2:0]            stat_sel_i,
  output logic [15:0]           stat_cnt_o
`endif
);

  xfer_state_e         state;
  logic [3:0]          endp_q;
  logic [CHANNELS-1:0] bulk_sel, route;
  logic                int_hit, bulk_hit, is_ctrl, mapped, live, bulk_go;
  logic                bulk_halted, bulk_valid, bulk_nak;
  logic [7:0]          bulk_data;

  always_comb begin
    bulk_sel    = '0;
    int_hit     = 1'b0;
    bulk_halted = 1'b0;
    bulk_valid  = 1'b0;
    bulk_nak    = 1'b0;
    bulk_data   = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (endp_i == endp_of(k, BULK_BASE, ENDP_STEP)) begin
        bulk_sel[k] = 1'b1;
        bulk_data   = bulk_in_data_i[8*k +: 8];
        bulk_valid  = bulk_in_valid_i[k];
        bulk_nak    = bulk_out_nak_i[k];
        bulk_halted = halted_o[k];
      end
      if (endp_i == endp_of(k, BULK_BASE, ENDP_STEP) + 4'd1)
        int_hit = 1'b1;
    end
  end

  assign live     = rstn_i & ~usb_reset_i;
  assign is_ctrl  = (endp_i == ENDP_CTRL);
  assign bulk_hit = |bulk_sel;
  assign mapped   = is_ctrl | bulk_hit | int_hit;
  assign bulk_go  = live & bulk_hit & configured_i & ~bulk_halted;
  assign route    = bulk_sel & {CHANNELS{bulk_go}};

  assign ctrl_in_req_o    = live & is_ctrl & in_req_i;
  assign ctrl_in_ready_o  = live & is_ctrl & in_ready_i;
  assign ctrl_out_ready_o = live & is_ctrl & out_ready_i;
  assign bulk_in_req_o    = route & {CHANNELS{in_req_i}};
  assign bulk_in_ready_o  = route & {CHANNELS{in_ready_i}};
  assign bulk_out_ready_o = route & {CHANNELS{out_ready_i}};

  // Interrupt endpoints have no data source here, so they always NAK.
  always_comb begin
    in_data_o  = ctrl_in_data_i;
    in_valid_o = 1'b0;
    in_zlp_o   = 1'b0;
    in_nak_o   = 1'b0;
    out_nak_o  = 1'b0;
    stall_o    = 1'b0;
    if (live) begin
      if (is_ctrl) begin
        in_valid_o = ctrl_in_valid_i;
        in_zlp_o   = ctrl_in_zlp_i;
        stall_o    = ctrl_stall_i;
      end else if (bulk_hit || int_hit) begin
        if (!configured_i || int_hit) begin
          in_nak_o  = 1'b1;
          out_nak_o = 1'b1;
        end else if (bulk_halted) begin
          stall_o = 1'b1;
        end else begin
          in_data_o  = bulk_data;
          in_valid_o = bulk_valid;
          out_nak_o  = bulk_nak;
        end
      end else begin
        stall_o = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state  <= ST_IDLE;
      endp_q <= ENDP_CTRL;
    end else begin
      endp_q <= endp_i;
      if (usb_reset_i) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (in_req_i && mapped)
              state <= ST_IN_XFER;
            else if (out_valid_i && mapped)
              state <= ST_OUT_XFER;
          end
          default: begin
            if (in_data_ack_i || out_ready_i || out_err_i || (endp_i != endp_q))
              state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_halt
    usb_endp_halt u_halt (
      .clk_i          (clk_i),
      .rstn_i         (rstn_i),
      .usb_reset_i    (usb_reset_i),
      .apply_i        (state == ST_IDLE),
      .set_i          (halt_set_i[g]),
      .clr_i          (halt_clr_i[g]),
      .halted_o       (halted_o[g]),
      .toggle_reset_o (toggle_reset_o[g])
    );
  end

`ifdef USB_ENDP_ROUTER_STATS_EN
  logic [15:0] stat_cnt [CHANNELS];
  logic [15:0] stat_pick;

  always_comb begin
    stat_pick = '0;
    for (int k = 0; k < CHANNELS; k++)
      if (stat_sel_i == 3'(k))
        stat_pick = stat_cnt[k];
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int k = 0; k < CHANNELS; k++)
        stat_cnt[k] <= '0;
      stat_cnt_o <= '0;
    end else if (usb_reset_i) begin
      for (int k = 0; k < CHANNELS; k++)
        stat_cnt[k] <= '0;
      stat_cnt_o <= '0;
    end else begin
      for (int k = 0; k < CHANNELS; k++)
        if (route[k] && (in_data_ack_i || out_ready_i) && (stat_cnt[k] != 16'hFFFF))
          stat_cnt[k] <= stat_cnt[k] + 16'd1;
      stat_cnt_o <= stat_pick;
    end
  end
`endif

endmodule

// File: tb/tb_usb_endp_router.sv
// tb/tb_usb_endp_router.sv - self-checking bench for usb_endp_router (3 channels)
module tb_usb_endp_router;
  localparam int CH = 3;
  localparam int BASE = 1;
  localparam int STEP = 2;

  logic clk_i = 0, rstn_i = 0, usb_reset_i = 0, configured_i = 0;
  logic [3:0] endp_i = 0;
  logic in_req_i = 0, in_ready_i = 0, in_data_ack_i = 0, out_valid_i = 0, out_ready_i = 0, out_err_i = 0;
  logic [7:0] in_data_o;
  logic in_valid_o, in_zlp_o, in_nak_o, out_nak_o, stall_o;
  logic [7:0] ctrl_in_data_i = 0;
  logic ctrl_in_valid_i = 0, ctrl_in_zlp_i = 0, ctrl_stall_i = 0;
  logic ctrl_in_req_o, ctrl_in_ready_o, ctrl_out_ready_o;
  logic [8*CH-1:0] bulk_in_data_i = 0;
  logic [CH-1:0] bulk_in_valid_i = 0, bulk_out_nak_i = 0;
  logic [CH-1:0] bulk_in_req_o, bulk_in_ready_o, bulk_out_ready_o;
  logic [CH-1:0] halt_set_i = 0, halt_clr_i = 0, halted_o, toggle_reset_o;
`ifdef USB_ENDP_ROUTER_STATS_EN
  logic [2:0] stat_sel_i = 0;
  logic [15:0] stat_cnt_o;
`endif

  int chk_cnt = 0;
  int pass_cnt = 0;

  usb_endp_router #(.CHANNELS(CH), .BULK_BASE(BASE), .ENDP_STEP(STEP)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .usb_reset_i(usb_reset_i), .configured_i(configured_i),
    .endp_i(endp_i), .in_req_i(in_req_i), .in_ready_i(in_ready_i), .in_data_ack_i(in_data_ack_i),
    .out_valid_i(out_valid_i), .out_ready_i(out_ready_i), .out_err_i(out_err_i),
    .in_data_o(in_data_o), .in_valid_o(in_valid_o), .in_zlp_o(in_zlp_o), .in_nak_o(in_nak_o),
    .out_nak_o(out_nak_o), .stall_o(stall_o),
    .ctrl_in_data_i(ctrl_in_data_i), .ctrl_in_valid_i(ctrl_in_valid_i), .ctrl_in_zlp_i(ctrl_in_zlp_i),
    .ctrl_stall_i(ctrl_stall_i), .ctrl_in_req_o(ctrl_in_req_o), .ctrl_in_ready_o(ctrl_in_ready_o),
    .ctrl_out_ready_o(ctrl_out_ready_o),
    .bulk_in_data_i(bulk_in_data_i), .bulk_in_valid_i(bulk_in_valid_i), .bulk_out_nak_i(bulk_out_nak_i),
    .bulk_in_req_o(bulk_in_req_o), .bulk_in_ready_o(bulk_in_ready_o), .bulk_out_ready_o(bulk_out_ready_o),
    .halt_set_i(halt_set_i), .halt_clr_i(halt_clr_i), .halted_o(halted_o), .toggle_reset_o(toggle_reset_o)
`ifdef USB_ENDP_ROUTER_STATS_EN
    , .stat_sel_i(stat_sel_i), .stat_cnt_o(stat_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [7:0] data;
    logic valid, zlp, in_nak, out_nak, stall;
    logic [2:0] ctrl;
    logic [CH-1:0] breq, brdy, bout;
  } obs_t;

  obs_t act;
  assign act = '{data: in_data_o, valid: in_valid_o, zlp: in_zlp_o, in_nak: in_nak_o, out_nak: out_nak_o,
                 stall: stall_o, ctrl: {ctrl_in_req_o, ctrl_in_ready_o, ctrl_out_ready_o},
                 breq: bulk_in_req_o, brdy: bulk_in_ready_o, bout: bulk_out_ready_o};

  // Reference: endpoint classification by arithmetic on the endpoint number.
  function automatic obs_t model(input logic [CH-1:0] hal);
    obs_t o;
    int e, kb, ki;
    bit is_bulk, is_int;
    o = '0;
    o.data = ctrl_in_data_i;
    e = int'(endp_i);
    kb = (e - BASE) / STEP;
    ki = (e - BASE - 1) / STEP;
    is_bulk = (e >= BASE) && ((e - BASE) % STEP == 0) && (kb < CH);
    is_int = (e >= BASE + 1) && ((e - BASE - 1) % STEP == 0) && (ki < CH);
    if (!rstn_i || usb_reset_i) return o;
    if (e == 0) begin
      o.valid = ctrl_in_valid_i;
      o.zlp = ctrl_in_zlp_i;
      o.stall = ctrl_stall_i;
      o.ctrl = {in_req_i, in_ready_i, out_ready_i};
    end else if (is_bulk || is_int) begin
      if (!configured_i || is_int) begin
        o.in_nak = 1;
        o.out_nak = 1;
      end else if (hal[kb]) begin
        o.stall = 1;
      end else begin
        o.data = bulk_in_data_i[8*kb +: 8];
        o.valid = bulk_in_valid_i[kb];
        o.out_nak = bulk_out_nak_i[kb];
        o.breq[kb] = in_req_i;
        o.brdy[kb] = in_ready_i;
        o.bout[kb] = out_ready_i;
      end
    end else begin
      o.stall = 1;
    end
    return o;
  endfunction

  task automatic clear_inputs();
    in_req_i = 0; in_ready_i = 0; in_data_ack_i = 0; out_valid_i = 0; out_ready_i = 0; out_err_i = 0;
    halt_set_i = 0; halt_clr_i = 0; usb_reset_i = 0;
  endtask

  task automatic go_idle();
    @(negedge clk_i);
    clear_inputs();
    out_err_i = 1;
    @(negedge clk_i);
    out_err_i = 0;
  endtask

  task automatic test_reset();
    obs_t exp;
    ctrl_in_data_i = 8'h5A; endp_i = 4'd1; configured_i = 1; in_req_i = 1; out_ready_i = 1;
    bulk_in_valid_i = '1;
    repeat (3) @(negedge clk_i);
    exp = model('0);
    chk_cnt++;
    if (act !== exp) $display("FAIL reset_outputs: got %h want %h", act, exp);
    else pass_cnt++;
    chk_cnt++;
    if ({halted_o, toggle_reset_o} !== '0) $display("FAIL reset_halt: got %b want 0", {halted_o, toggle_reset_o});
    else pass_cnt++;
    chk_cnt++;
    if (in_data_o !== 8'h5A) $display("FAIL reset_data: got %h want 5a", in_data_o);
    else pass_cnt++;
    rstn_i = 1;
    clear_inputs();
    @(negedge clk_i);
  endtask

  task automatic test_directed();
    @(negedge clk_i);
    configured_i = 1;
    bulk_in_data_i = 24'hC3_B2_A1;
    bulk_in_valid_i = 3'b111;
    endp_i = 4'd5; in_req_i = 1;
    #1;
    chk_cnt++;
    if (bulk_in_req_o !== 3'b100 || in_data_o !== 8'hC3)
      $display("FAIL ep5_in: req %b data %h want 100 c3", bulk_in_req_o, in_data_o);
    else pass_cnt++;
    @(negedge clk_i);
    endp_i = 4'd4;
    #1;
    chk_cnt++;
    if (in_nak_o !== 1 || in_valid_o !== 0 || bulk_in_req_o !== 0)
      $display("FAIL ep4_int: nak %b valid %b req %b want 1 0 000", in_nak_o, in_valid_o, bulk_in_req_o);
    else pass_cnt++;
    @(negedge clk_i);
    endp_i = 4'd9; in_ready_i = 1; out_ready_i = 1;
    #1;
    chk_cnt++;
    if (stall_o !== 1 || {bulk_in_req_o, bulk_in_ready_o, bulk_out_ready_o, ctrl_in_req_o} !== 0)
      $display("FAIL ep9_stall: stall %b strobes %b want 1 0", stall_o,
               {bulk_in_req_o, bulk_in_ready_o, bulk_out_ready_o, ctrl_in_req_o});
    else pass_cnt++;
    @(negedge clk_i);
    clear_inputs();
    configured_i = 0; endp_i = 4'd1; out_valid_i = 1; out_ready_i = 1;
    #1;
    chk_cnt++;
    if (out_nak_o !== 1 || bulk_out_ready_o !== 0)
      $display("FAIL unconf_out: nak %b ready %b want 1 000", out_nak_o, bulk_out_ready_o);
    else pass_cnt++;
    @(negedge clk_i);
    endp_i = 4'd0;
    #1;
    chk_cnt++;
    if (ctrl_out_ready_o !== 1 || out_nak_o !== 0)
      $display("FAIL unconf_ctrl: ready %b nak %b want 1 0", ctrl_out_ready_o, out_nak_o);
    else pass_cnt++;
    clear_inputs();
    configured_i = 1;
  endtask

  task automatic test_random_decode(input logic [CH-1:0] hal, input int n);
    obs_t exp;
    for (int i = 0; i < n; i++) begin
      @(negedge clk_i);
      endp_i = 4'($urandom_range(0, 15));
      configured_i = ($urandom_range(0, 3) != 0);
      in_req_i = 1'($urandom); in_ready_i = 1'($urandom); out_ready_i = 1'($urandom);
      out_valid_i = 1'($urandom);
      ctrl_in_data_i = 8'($urandom); ctrl_in_valid_i = 1'($urandom);
      ctrl_in_zlp_i = 1'($urandom); ctrl_stall_i = 1'($urandom);
      bulk_in_data_i = 24'($urandom); bulk_in_valid_i = 3'($urandom); bulk_out_nak_i = 3'($urandom);
      #1;
      exp = model(hal);
      chk_cnt++;
      if (act !== exp) $display("FAIL rand_decode ep%0d cfg%0b: got %h want %h", endp_i, configured_i, act, exp);
      else pass_cnt++;
    end
    clear_inputs();
    configured_i = 1;
  endtask

  task automatic test_halt();
    go_idle();
    endp_i = 4'd1; configured_i = 1; in_req_i = 1;
    @(negedge clk_i);
    in_req_i = 0; halt_set_i = 3'b001;
    @(negedge clk_i);
    halt_set_i = 0;
    chk_cnt++;
    if (halted_o !== 3'b000) $display("FAIL halt_mid_xfer_a: got %b want 000", halted_o);
    else pass_cnt++;
    @(negedge clk_i);
    chk_cnt++;
    if (halted_o !== 3'b000) $display("FAIL halt_mid_xfer_b: got %b want 000", halted_o);
    else pass_cnt++;
    in_data_ack_i = 1;
    @(negedge clk_i);
    in_data_ack_i = 0;
    @(negedge clk_i);
    chk_cnt++;
    if (halted_o !== 3'b001) $display("FAIL halt_after_ack: got %b want 001", halted_o);
    else pass_cnt++;
    bulk_in_valid_i = 3'b111; in_req_i = 1; endp_i = 4'd1;
    #1;
    chk_cnt++;
    if (stall_o !== 1 || in_valid_o !== 0 || bulk_in_req_o !== 0)
      $display("FAIL halted_stall: stall %b valid %b req %b want 1 0 000", stall_o, in_valid_o, bulk_in_req_o);
    else pass_cnt++;
    @(negedge clk_i);
    in_req_i = 0; endp_i = 4'd0;
    @(negedge clk_i);
    halt_clr_i = 3'b001;
    @(negedge clk_i);
    halt_clr_i = 0;
    chk_cnt++;
    if (toggle_reset_o !== 3'b001 || halted_o !== 3'b000)
      $display("FAIL halt_clr: toggle %b halted %b want 001 000", toggle_reset_o, halted_o);
    else pass_cnt++;
    @(negedge clk_i);
    chk_cnt++;
    if (toggle_reset_o !== 3'b000) $display("FAIL toggle_width: got %b want 000", toggle_reset_o);
    else pass_cnt++;
    halt_clr_i = 3'b010;
    @(negedge clk_i);
    halt_clr_i = 0;
    chk_cnt++;
    if (toggle_reset_o !== 3'b010) $display("FAIL clr_unhalted: got %b want 010", toggle_reset_o);
    else pass_cnt++;
    halt_set_i = 3'b100; halt_clr_i = 3'b100;
    @(negedge clk_i);
    halt_set_i = 0; halt_clr_i = 0;
    chk_cnt++;
    if (halted_o !== 3'b000 || toggle_reset_o !== 3'b100)
      $display("FAIL set_clr_both: halted %b toggle %b want 000 100", halted_o, toggle_reset_o);
    else pass_cnt++;
    halt_set_i = 3'b010;
    @(negedge clk_i);
    halt_set_i = 0;
    @(negedge clk_i);
    chk_cnt++;
    if (halted_o !== 3'b010) $display("FAIL halt_ch1: got %b want 010", halted_o);
    else pass_cnt++;
  endtask

  task automatic test_usb_reset();
    go_idle();
    endp_i = 4'd1; out_valid_i = 1; ctrl_in_data_i = 8'h3C;
    @(negedge clk_i);
    out_valid_i = 0; usb_reset_i = 1; out_ready_i = 1; in_req_i = 1; in_ready_i = 1;
    #1;
    chk_cnt++;
    if ({bulk_in_req_o, bulk_in_ready_o, bulk_out_ready_o, ctrl_in_req_o, ctrl_in_ready_o, ctrl_out_ready_o} !== 0
        || in_data_o !== 8'h3C)
      $display("FAIL usbrst_strobes: strobes %b data %h want 0 3c",
               {bulk_in_req_o, bulk_in_ready_o, bulk_out_ready_o}, in_data_o);
    else pass_cnt++;
    @(negedge clk_i);
    clear_inputs();
    chk_cnt++;
    if (halted_o !== 3'b000) $display("FAIL usbrst_halted: got %b want 000", halted_o);
    else pass_cnt++;
    halt_set_i = 3'b001;
    @(negedge clk_i);
    halt_set_i = 0;
    chk_cnt++;
    if (halted_o !== 3'b001) $display("FAIL usbrst_idle: got %b want 001", halted_o);
    else pass_cnt++;
    halt_clr_i = 3'b001;
    @(negedge clk_i);
    halt_clr_i = 0;
    @(negedge clk_i);
  endtask

`ifdef USB_ENDP_ROUTER_STATS_EN
  task automatic test_stats();
    go_idle();
    usb_reset_i = 1;
    @(negedge clk_i);
    usb_reset_i = 0; configured_i = 1; endp_i = 4'd3; stat_sel_i = 3'd1;
    in_data_ack_i = 1;
    repeat (10) @(negedge clk_i);
    in_data_ack_i = 0;
    @(negedge clk_i);
    chk_cnt++;
    if (stat_cnt_o !== 16'd10) $display("FAIL stat_ch1_10: got %0d want 10", stat_cnt_o);
    else pass_cnt++;
    stat_sel_i = 3'd0;
    @(negedge clk_i);
    chk_cnt++;
    if (stat_cnt_o !== 16'd0) $display("FAIL stat_ch0: got %0d want 0", stat_cnt_o);
    else pass_cnt++;
    stat_sel_i = 3'd1;
    in_data_ack_i = 1;
    repeat (65530) @(negedge clk_i);
    in_data_ack_i = 0;
    @(negedge clk_i);
    chk_cnt++;
    if (stat_cnt_o !== 16'hFFFF) $display("FAIL stat_sat: got %h want ffff", stat_cnt_o);
    else pass_cnt++;
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_random_decode(3'b000, 150);
    test_halt();
    go_idle();
    test_random_decode(3'b010, 150);
    test_usb_reset();
`ifdef USB_ENDP_ROUTER_STATS_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
